alu_arbiter: RTL and testbench

- Shares one combinational `alu` instance (instruction, regA, regB -> result, flags[2:0]) between two requesters, e.g. the integer pipe and the branch/address unit.
- Arbitrates round-robin under valid/ready handshakes.
- Registers the ALU output into a single response slot, so latency is exactly one cycle.
- Keeps per-requester saturating grant counters and an overflow-event counter for debug.

---
 rtl/alu_pkg.sv | 49 ++++
 rtl/alu_arbiter_alu.sv | 98 +++++++++
 rtl/alu_arbiter.sv | 135 +++++++++++++
 tb/tb_alu_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared MIPS ALU encodings, flag positions and response-slot state type
// used by the ALU and by the arbiter that shares it.
package alu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;

    localparam logic [5:0] ADD  = 6'b100000;
    localparam logic [5:0] ADDU = 6'b100001;
    localparam logic [5:0] SUB  = 6'b100010;
    localparam logic [5:0] SUBU = 6'b100011;
    localparam logic [5:0] AND  = 6'b100100;
    localparam logic [5:0] OR   = 6'b100101;
    localparam logic [5:0] XOR  = 6'b100110;
    localparam logic [5:0] NOR  = 6'b100111;
    localparam logic [5:0] SLT  = 6'b101010;
    localparam logic [5:0] SLTU = 6'b101011;
    localparam logic [5:0] SLL  = 6'b000000;
    localparam logic [5:0] SRL  = 6'b000010;
    localparam logic [5:0] SRA  = 6'b000011;
    localparam logic [5:0] SLLV = 6'b000100;
    localparam logic [5:0] SRLV = 6'b000110;
    localparam logic [5:0] SRAV = 6'b000111;

    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam int FLAG_ZERO = 2;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_OVF  = 0;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational MIPS ALU: R-type and immediate arithmetic/logic,
// shifts, set-less-than, branch compare and load/store address generation.
module alu
    import alu_pkg::*;
(
    input  logic [31:0] instruction,
    input  logic [31:0] rega,
    input  logic [31:0] regb,
    output logic [31:0] result,
    output logic [2:0]  flags
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] simm;
    logic [31:0] zimm;
    logic [31:0] sum_ab;
    logic [31:0] diff_ab;
    logic [31:0] sum_ai;
    logic        ovf_add;
    logic        ovf_sub;
    logic        ovf_addi;
    logic        lt_s;
    logic        lt_u;
    logic        lt_si;
    logic        lt_ui;
    logic        is_lt;
    logic        is_ovf;
    logic        unused_bits;

    assign opcode      = instruction[31:26];
    assign funct       = instruction[5:0];
    assign shamt       = instruction[10:6];
    assign simm        = sign_ext16(instruction[15:0]);
    assign zimm        = {16'd0, instruction[15:0]};
    // Register-specifier fields are resolved outside the ALU.
    assign unused_bits = ^instruction[25:16];

    assign sum_ab   = rega + regb;
    assign diff_ab  = rega - regb;
    assign sum_ai   = rega + simm;
    assign ovf_add  = (rega[31] == regb[31]) && (sum_ab[31] != rega[31]);
    assign ovf_sub  = (rega[31] != regb[31]) && (diff_ab[31] != rega[31]);
    assign ovf_addi = (rega[31] == simm[31]) && (sum_ai[31] != rega[31]);
    assign lt_s     = $signed(rega) < $signed(regb);
    assign lt_u     = rega < regb;
    assign lt_si    = $signed(rega) < $signed(simm);
    assign lt_ui    = rega < simm;

    always_comb begin
        result = '0;
        is_lt  = 1'b0;
        is_ovf = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    ADD:  begin result = sum_ab;  is_ovf = ovf_add; end
                    ADDU: result = sum_ab;
                    SUB:  begin result = diff_ab; is_ovf = ovf_sub; end
                    SUBU: result = diff_ab;
                    AND:  result = rega & regb;
                    OR:   result = rega | regb;
                    XOR:  result = rega ^ regb;
                    NOR:  result = ~(rega | regb);
                    SLT:  begin is_lt = lt_s; result = {31'd0, lt_s}; end
                    SLTU: begin is_lt = lt_u; result = {31'd0, lt_u}; end
                    SLL:  result = regb << shamt;
                    SRL:  result = regb >> shamt;
                    SRA:  result = $signed(regb) >>> shamt;
                    SLLV: result = regb << rega[4:0];
                    SRLV: result = regb >> rega[4:0];
                    SRAV: result = $signed(regb) >>> rega[4:0];
                    default: result = '0;
                endcase
            end
            OP_ADDI:  begin result = sum_ai; is_ovf = ovf_addi; end
            OP_ADDIU: result = sum_ai;
            OP_SLTI:  begin is_lt = lt_si; result = {31'd0, lt_si}; end
            OP_SLTIU: begin is_lt = lt_ui; result = {31'd0, lt_ui}; end
            OP_ANDI:  result = rega & zimm;
            OP_ORI:   result = rega | zimm;
            OP_XORI:  result = rega ^ zimm;
            // Branches compare by subtraction so zero means equal.
            OP_BEQ, OP_BNE: result = diff_ab;
            OP_LW, OP_SW:   result = sum_ai;
            default: result = '0;
        endcase
    end

    always_comb begin
        flags            = '0;
        flags[FLAG_ZERO] = (result == 32'd0);
        flags[FLAG_NEG]  = is_lt;
        flags[FLAG_OVF]  = is_ovf;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a single
// registered response slot and saturating debug counters.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int CNT_W   = 16
)
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [32*NUM_REQ-1:0]    req_instr,
    input  logic [32*NUM_REQ-1:0]    req_rega,
    input  logic [32*NUM_REQ-1:0]    req_regb,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_id,
    output logic [31:0]              rsp_result,
    output logic [2:0]               rsp_flags,
    output logic [NUM_REQ*CNT_W-1:0] grant_cnt,
    output logic [CNT_W-1:0]         ovf_cnt
);

    slot_state_e      state_q;
    slot_state_e      state_d;
    logic             last_grant_q;
    logic             last_grant_d;
    logic             rsp_id_q;
    logic [31:0]      rsp_result_q;
    logic [2:0]       rsp_flags_q;
    logic [CNT_W-1:0] ovf_cnt_q;
    logic             slot_free;
    logic             gnt_any;
    logic             gnt_idx;
    logic [31:0]      alu_instr;
    logic [31:0]      alu_rega;
    logic [31:0]      alu_regb;
    logic [31:0]      alu_result;
    logic [2:0]       alu_flags;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_any      = 1'b0;
        gnt_idx      = 1'b0;
        req_ready    = '0;
        slot_free    = (state_q == SLOT_EMPTY) || rsp_ready;

        // Reset also masks grants so nothing is accepted while it is held.
        if (slot_free && !reset) begin
            if (req_valid[0] && req_valid[1]) begin
                gnt_any = 1'b1;
                gnt_idx = ~last_grant_q;
            end else if (req_valid[0]) begin
                gnt_any = 1'b1;
                gnt_idx = 1'b0;
            end else if (req_valid[1]) begin
                gnt_any = 1'b1;
                gnt_idx = 1'b1;
            end
        end

        if (gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
            state_d            = SLOT_FULL;
            last_grant_d       = gnt_idx;
        end else if ((state_q == SLOT_FULL) && rsp_ready) begin
            state_d = SLOT_EMPTY;
        end
    end

    // With no grant gnt_idx is 0, so the idle ALU sees requester 0.
    assign alu_instr = gnt_idx ? req_instr[63:32] : req_instr[31:0];
    assign alu_rega  = gnt_idx ? req_rega[63:32]  : req_rega[31:0];
    assign alu_regb  = gnt_idx ? req_regb[63:32]  : req_regb[31:0];

    alu u_alu (
        .instruction (alu_instr),
        .rega        (alu_rega),
        .regb        (alu_regb),
        .result      (alu_result),
        .flags       (alu_flags)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= SLOT_EMPTY;
            last_grant_q <= 1'b1;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            if (gnt_any) begin
                rsp_id_q     <= gnt_idx;
                rsp_result_q <= alu_result;
                rsp_flags_q  <= alu_flags;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_cnt_q <= '0;
        end else if (gnt_any && alu_flags[FLAG_OVF] && (ovf_cnt_q != {CNT_W{1'b1}})) begin
            ovf_cnt_q <= ovf_cnt_q + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant_cnt
            logic [CNT_W-1:0] cnt_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q <= '0;
                end else if (req_valid[gi] && req_ready[gi] && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign grant_cnt[gi*CNT_W +: CNT_W] = cnt_q;
        end
    endgenerate

    assign rsp_valid  = (state_q == SLOT_FULL);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign ovf_cnt    = ovf_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of arbitration, slot and ALU.
module tb_alu_arbiter;

    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [63:0]    req_instr;
    logic [63:0]    req_rega;
    logic [63:0]    req_regb;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [31:0]    rsp_result;
    logic [2:0]     rsp_flags;
    logic [2*CW-1:0] grant_cnt;
    logic [CW-1:0]  ovf_cnt;

    int checks = 0;
    int failures = 0;

    logic [5:0] r_fn [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                              6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    logic [5:0] i_op [11] = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e,
                              6'h04, 6'h05, 6'h23, 6'h2b};

    alu_arbiter #(.NUM_REQ(2), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_instr  (req_instr),
        .req_rega   (req_rega),
        .req_regb   (req_regb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .grant_cnt  (grant_cnt),
        .ovf_cnt    (ovf_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_r(input logic [5:0] fn);
        logic [31:0] rnd;
        rnd = $urandom;
        return {6'd0, rnd[19:0], fn};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [15:0] imm);
        logic [31:0] rnd;
        rnd = $urandom;
        return {op, rnd[9:0], imm};
    endfunction

    function automatic logic [31:0] rand_instr();
        int k;
        k = $urandom_range(0, 26);
        if (k < 16) return mk_r(r_fn[k]);
        return mk_i(i_op[k-16], 16'($urandom));
    endfunction

    // Reference ALU in wide signed arithmetic: overflow means the true result
    // does not fit in 32 signed bits.
    function automatic void ref_alu(input logic [31:0] ins, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output logic [2:0] f);
        longint sa, sb, si, s;
        logic [31:0] simm, zimm;
        logic lt, ov;
        logic [4:0] sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        simm = {{16{ins[15]}}, ins[15:0]};
        zimm = {16'd0, ins[15:0]};
        si = longint'($signed(simm));
        sh = ins[10:6];
        r = 32'd0; lt = 1'b0; ov = 1'b0; s = 0;
        if (ins[31:26] == 6'h00) begin
            case (ins[5:0])
                6'h20: begin s = sa + sb; r = s[31:0]; ov = (s != longint'($signed(r))); end
                6'h21: r = a + b;
                6'h22: begin s = sa - sb; r = s[31:0]; ov = (s != longint'($signed(r))); end
                6'h23: r = a - b;
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h26: r = a ^ b;
                6'h27: r = ~(a | b);
                6'h2a: begin lt = (sa < sb); r = {31'd0, lt}; end
                6'h2b: begin lt = (a < b); r = {31'd0, lt}; end
                6'h00: r = b << sh;
                6'h02: r = b >> sh;
                6'h03: begin s = sb >>> sh; r = s[31:0]; end
                6'h04: r = b << a[4:0];
                6'h06: r = b >> a[4:0];
                6'h07: begin s = sb >>> a[4:0]; r = s[31:0]; end
                default: r = 32'd0;
            endcase
        end else begin
            case (ins[31:26])
                6'h08: begin s = sa + si; r = s[31:0]; ov = (s != longint'($signed(r))); end
                6'h09: r = a + simm;
                6'h0a: begin lt = (sa < si); r = {31'd0, lt}; end
                6'h0b: begin lt = (a < simm); r = {31'd0, lt}; end
                6'h0c: r = a & zimm;
                6'h0d: r = a | zimm;
                6'h0e: r = a ^ zimm;
                6'h04, 6'h05: r = a - b;
                6'h23, 6'h2b: r = a + simm;
                default: r = 32'd0;
            endcase
        end
        f = {(r == 32'd0), lt, ov};
    endfunction

    task automatic drive(input int i, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b);
        req_instr[i*32 +: 32] = ins;
        req_rega[i*32 +: 32]  = a;
        req_regb[i*32 +: 32]  = b;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        req_instr = '0; req_rega = '0; req_regb = '0;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
        checks++; if ({rsp_id, rsp_result, rsp_flags} !== 36'd0) begin failures++; $display("FAIL reset_slot: got id=%b res=%h fl=%b expected zeros", rsp_id, rsp_result, rsp_flags); end
        checks++; if ({grant_cnt, ovf_cnt} !== '0) begin failures++; $display("FAIL reset_counters: got gnt=%h ovf=%h expected 0", grant_cnt, ovf_cnt); end
        req_valid = 2'b00;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_add();
        do_reset();
        rsp_ready = 1'b1;
        drive(0, mk_r(6'h20), 32'd1, 32'd1);
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL add_ready: got %b expected 01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        checks++; if ({rsp_valid, rsp_id, rsp_result, rsp_flags} !== {1'b1, 1'b0, 32'd2, 3'b000})
            begin failures++; $display("FAIL add_rsp: got v=%b id=%b res=%h fl=%b expected v=1 id=0 res=2 fl=000", rsp_valid, rsp_id, rsp_result, rsp_flags); end
        checks++; if (grant_cnt !== 8'h01) begin failures++; $display("FAIL add_gcnt: got %h expected 01", grant_cnt); end
    endtask

    task automatic test_simultaneous();
        logic [1:0] exp_rdy;
        do_reset();
        rsp_ready = 1'b1;
        drive(0, mk_r(6'h22), 32'd1, 32'd1);
        drive(1, mk_r(6'h22), 32'd1, 32'd1);
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL tie_ready[%0d]: got %b expected %b", k, req_ready, exp_rdy); end
            @(posedge clk); #1;
            checks++; if ({rsp_valid, rsp_id, rsp_result, rsp_flags} !== {1'b1, 1'(k % 2), 32'd0, 3'b100})
                begin failures++; $display("FAIL tie_rsp[%0d]: got v=%b id=%b res=%h fl=%b expected id=%0d res=0 fl=100", k, rsp_valid, rsp_id, rsp_result, rsp_flags, k % 2); end
        end
        req_valid = 2'b00;
        checks++; if (grant_cnt !== 8'h33) begin failures++; $display("FAIL tie_gcnt: got %h expected 33", grant_cnt); end
    endtask

    task automatic test_backpressure();
        do_reset();
        rsp_ready = 1'b0;
        drive(0, mk_r(6'h20), 32'd5, 32'd7);
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL bp_first_ready: got %b expected 01", req_ready); end
        @(posedge clk); #1;
        drive(0, mk_r(6'h20), 32'd10, 32'd20);
        drive(1, mk_r(6'h20), 32'd100, 32'd1);
        req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL bp_stall_ready[%0d]: got %b expected 00", k, req_ready); end
            checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 32'd12})
                begin failures++; $display("FAIL bp_stall_rsp[%0d]: got v=%b id=%b res=%h expected v=1 id=0 res=c", k, rsp_valid, rsp_id, rsp_result); end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL bp_refill_ready: got %b expected 10", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b1, 32'd101})
            begin failures++; $display("FAIL bp_refill_rsp: got v=%b id=%b res=%h expected v=1 id=1 res=65", rsp_valid, rsp_id, rsp_result); end
    endtask

    task automatic test_overflow();
        do_reset();
        rsp_ready = 1'b1;
        drive(1, mk_r(6'h20), 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        req_valid = 2'b10;
        #1;
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL ovf_ready: got %b expected 10", req_ready); end
        @(posedge clk); #1;
        checks++; if ({rsp_id, rsp_flags[0], ovf_cnt} !== {1'b1, 1'b1, 4'd1})
            begin failures++; $display("FAIL ovf_add: got id=%b fl=%b ovf_cnt=%0d expected id=1 fl[0]=1 ovf_cnt=1", rsp_id, rsp_flags, ovf_cnt); end
        drive(1, mk_r(6'h21), 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        @(posedge clk); #1;
        req_valid = 2'b00;
        checks++; if ({rsp_result, rsp_flags[0], ovf_cnt} !== {32'hFFFF_FFFE, 1'b0, 4'd1})
            begin failures++; $display("FAIL ovf_addu: got res=%h fl=%b ovf_cnt=%0d expected res=fffffffe fl[0]=0 ovf_cnt=1", rsp_result, rsp_flags, ovf_cnt); end
    endtask

    task automatic test_branch_compare();
        logic [31:0] ins [3];
        logic [31:0] a [3];
        logic [31:0] b [3];
        logic [2:0]  ef [3];
        ins[0] = mk_i(6'h04, 16'h0010); a[0] = 32'd1;          b[0] = 32'd1; ef[0] = 3'b100;
        ins[1] = mk_i(6'h05, 16'h0010); a[1] = 32'd1;          b[1] = 32'd0; ef[1] = 3'b000;
        ins[2] = mk_r(6'h2a);           a[2] = 32'hFFFF_FFFF;  b[2] = 32'd1; ef[2] = 3'b010;
        do_reset();
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(0, ins[k], a[k], b[k]);
            req_valid = 2'b01;
            @(posedge clk); #1;
            checks++; if ({rsp_valid, rsp_flags} !== {1'b1, ef[k]})
                begin failures++; $display("FAIL cmp[%0d]: got v=%b fl=%b expected v=1 fl=%b", k, rsp_valid, rsp_flags, ef[k]); end
        end
        req_valid = 2'b00;
    endtask

    task automatic test_reset_mid();
        do_reset();
        rsp_ready = 1'b0;
        drive(0, mk_r(6'h20), 32'd3, 32'd4);
        drive(1, mk_r(6'h20), 32'd5, 32'd6);
        req_valid = 2'b11;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b expected 0", rsp_valid); end
        checks++; if ({grant_cnt, ovf_cnt, rsp_result} !== '0) begin failures++; $display("FAIL midrst_clear: got gnt=%h ovf=%h res=%h expected 0", grant_cnt, ovf_cnt, rsp_result); end
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL midrst_ready: got %b expected 00", req_ready); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL midrst_first_tie: got %b expected 01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 32'd7})
            begin failures++; $display("FAIL midrst_rsp: got v=%b id=%b res=%h expected v=1 id=0 res=7", rsp_valid, rsp_id, rsp_result); end
    endtask

    task automatic test_random();
        logic [31:0] ins [2];
        logic [31:0] ra [2];
        logic [31:0] rb [2];
        bit          hold [2];
        bit          m_full, m_last, m_id;
        logic [31:0] m_res, r;
        logic [2:0]  m_fl, f;
        int          m_cnt [2];
        int          m_ovf;
        int          g;
        logic [1:0]  exp_rdy;
        do_reset();
        m_full = 0; m_last = 1; m_id = 0; m_res = '0; m_fl = '0;
        m_cnt[0] = 0; m_cnt[1] = 0; m_ovf = 0; hold[0] = 0; hold[1] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!hold[i]) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    ins[i] = rand_instr();
                    ra[i] = $urandom;
                    rb[i] = ($urandom_range(0, 3) == 0) ? ra[i] : $urandom;
                    drive(i, ins[i], ra[i], rb[i]);
                end
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            #1;
            g = -1;
            if (!m_full || rsp_ready) begin
                if (req_valid == 2'b11) g = m_last ? 0 : 1;
                else if (req_valid[0]) g = 0;
                else if (req_valid[1]) g = 1;
            end
            exp_rdy = (g < 0) ? 2'b00 : (2'b01 << g);
            checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rnd_ready[%0d]: got %b expected %b", cyc, req_ready, exp_rdy); end
            if (g >= 0) begin
                ref_alu(ins[g], ra[g], rb[g], r, f);
                m_full = 1; m_id = g[0]; m_res = r; m_fl = f; m_last = g[0];
                if (m_cnt[g] < SAT) m_cnt[g]++;
                if (f[0] && m_ovf < SAT) m_ovf++;
            end else if (m_full && rsp_ready) begin
                m_full = 0;
            end
            for (int i = 0; i < 2; i++) hold[i] = req_valid[i] && (g != i);
            @(posedge clk); #1;
            checks++; if ({rsp_valid, rsp_id, rsp_result, rsp_flags} !== {m_full, m_id, m_res, m_fl})
                begin failures++; $display("FAIL rnd_rsp[%0d]: got v=%b id=%b res=%h fl=%b expected v=%b id=%b res=%h fl=%b", cyc, rsp_valid, rsp_id, rsp_result, rsp_flags, m_full, m_id, m_res, m_fl); end
            checks++; if ({grant_cnt, ovf_cnt} !== {CW'(m_cnt[1]), CW'(m_cnt[0]), CW'(m_ovf)})
                begin failures++; $display("FAIL rnd_cnt[%0d]: got gnt=%h ovf=%0d expected gnt1=%0d gnt0=%0d ovf=%0d", cyc, grant_cnt, ovf_cnt, m_cnt[1], m_cnt[0], m_ovf); end
        end
        req_valid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_simultaneous();
        test_backpressure();
        test_overflow();
        test_branch_compare();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
